// File: rtl/game_pkg.sv
// Shared game constants and the obstacle scheduler state encoding.
package game_pkg;

    localparam int unsigned X_W         = 9;
    localparam int unsigned Y_W         = 9;
    localparam int unsigned SCREEN_W    = 320;
    localparam int unsigned START_X_DEF = 320;
    localparam int unsigned SPACING_DEF = 120;

    typedef enum logic [2:0] {
        IDLE,
        SCROLL,
        SPAWN_CHK,
        REQ,
        LOAD
    } sched_state_e;

endpackage

// File: rtl/tick_divider.sv
// Enable-gated free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_divider #(
    parameter int unsigned TICK_DIV = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Pipe slot pool: scrolls active slots each tick, retires at the left edge,
// and spawns a new slot at START_X with a height fetched over a req/ack handshake.
module obstacle_scheduler
    import game_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 3,
    parameter int unsigned TICK_DIV  = 2500000,
    parameter int unsigned START_X   = START_X_DEF,
    parameter int unsigned SPACING   = SPACING_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [3:0]               speed,
    output logic                     rnd_req,
    input  logic                     rnd_ack,
    input  logic [Y_W-1:0]           rnd_height,
    output logic                     tick,
    output logic [NUM_SLOTS-1:0]     active,
    output logic [NUM_SLOTS*X_W-1:0] x_flat,
    output logic [NUM_SLOTS*Y_W-1:0] y_flat
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [X_W-1:0] START_V   = X_W'(START_X);
    localparam logic [X_W-1:0] SPACING_V = X_W'(SPACING);

    sched_state_e          state_q, state_d;
    logic                  pending_q, pending_d;
    logic [X_W-1:0]        dist_q, dist_d;
    logic [Y_W-1:0]        hgt_q, hgt_d;
    logic [NUM_SLOTS-1:0]  active_q, active_d;
    logic [X_W-1:0]        x_q [NUM_SLOTS];
    logic [X_W-1:0]        x_d [NUM_SLOTS];
    logic [Y_W-1:0]        y_q [NUM_SLOTS];
    logic [Y_W-1:0]        y_d [NUM_SLOTS];

    logic                  free_found;
    logic [SLOT_W-1:0]     free_idx;
    logic [X_W-1:0]        spd;
    logic [X_W:0]          dist_sum;
    logic                  go_scroll;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    assign spd      = X_W'(speed);
    assign dist_sum = {1'b0, dist_q} + {1'b0, spd};
    // A tick arriving while idle starts the scroll directly instead of waiting a cycle in pending.
    assign go_scroll = (state_q == IDLE) && enable && (pending_q || tick);

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!active_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dist_d   = dist_q;
        hgt_d    = hgt_q;
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;

        if (go_scroll) begin
            pending_d = 1'b0;
        end else if (tick) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        case (state_q)
            IDLE: begin
                if (go_scroll) begin
                    state_d = SCROLL;
                end
            end
            SCROLL: begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (active_q[i]) begin
                        if (x_q[i] <= spd) begin
                            active_d[i] = 1'b0;
                        end else begin
                            x_d[i] = x_q[i] - spd;
                        end
                    end
                end
                dist_d  = dist_sum[X_W] ? '1 : dist_sum[X_W-1:0];
                state_d = SPAWN_CHK;
            end
            SPAWN_CHK: begin
                state_d = (dist_q >= SPACING_V && free_found) ? REQ : IDLE;
            end
            REQ: begin
                if (rnd_ack) begin
                    hgt_d   = rnd_height;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                x_d[free_idx]      = START_V;
                y_d[free_idx]      = hgt_q;
                active_d[free_idx] = 1'b1;
                dist_d             = '0;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            dist_q    <= SPACING_V;
            hgt_q     <= '0;
            active_q  <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dist_q    <= dist_d;
            hgt_q     <= hgt_d;
            active_q  <= active_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    always_comb begin
        x_flat = '0;
        y_flat = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            x_flat[i*X_W +: X_W] = x_q[i];
            y_flat[i*Y_W +: Y_W] = y_q[i];
        end
    end

    assign active  = active_q;
    assign rnd_req = (state_q == REQ);

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Owns a small pool of scrolling obstacle (pipe) slots.
- Generates the scroll tick internally and moves every active slot left by the speed selected on the switches.
- Retires slots that leave the left edge; spawns new slots at the right edge once enough distance has been scrolled.
- Fetches each new slot's gap height from the shared random-height generator via a req/ack handshake. Feeds the renderer and collision logic.

Parameters:
- NUM_SLOTS, 3, number of concurrent obstacle slots.
- TICK_DIV, 2500000, clk cycles per scroll tick.
- START_X, 320, x loaded into a newly spawned slot.
- SPACING, 120, scrolled pixels required between spawns.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  game running; low freezes scrolling.
- speed  in  4  pixels moved per tick (sw), sampled at tick.
- rnd_req  out  1  height request to random-height generator.
- rnd_ack  in  1  one-cycle acknowledge; rnd_height valid this cycle.
- rnd_height  in  9  gap height for new slot.
- tick  out  1  one-cycle pulse at each scroll tick.
- active  out  NUM_SLOTS  slot i occupied.
- x_flat  out  NUM_SLOTS*9  slot i x at bits [9i+8:9i].
- y_flat  out  NUM_SLOTS*9  slot i height at bits [9i+8:9i].

Behaviour:
- Reset values: tick=0, rnd_req=0, active=0, x_flat=0, y_flat=0. Tick counter=0, FSM=IDLE, pending=0, dist=SPACING (first tick spawns immediately).
- Tick divider:
  - Counts 0..TICK_DIV-1 only while enable=1; holds otherwise.
  - tick=1 in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
- pending flag:
  - Set by tick.
  - Cleared when the FSM leaves IDLE for SCROLL.
  - A second tick while pending=1 is dropped; no queueing beyond one.
- FSM states: IDLE, SCROLL, SPAWN_CHK, REQ, LOAD.
- IDLE: if pending=1 and enable=1, go to SCROLL.
- SCROLL (1 cycle):
  - Sample speed.
  - For each active slot: if x <= speed, clear active (retire). Otherwise x <= x - speed. No wrap.
  - dist <= min(dist + speed, 511).
  - Go to SPAWN_CHK.
- SPAWN_CHK (1 cycle):
  - If dist >= SPACING and any slot is free, go to REQ.
  - Otherwise go to IDLE; dist keeps its saturated value.
- REQ:
  - Assert rnd_req from the entry cycle and hold it until rnd_ack=1.
  - On ack, capture rnd_height and go to LOAD. rnd_req drops the next cycle.
  - Ack outside REQ is ignored.
  - enable falling during REQ does not abort the handshake.
- LOAD (1 cycle):
  - The lowest-index free slot gets x=START_X, y=captured height, active=1.
  - dist <= 0.
  - Go to IDLE.
  - At most one spawn per tick.
- speed=0: no movement, no retire, dist unchanged. A spawn can still occur if dist >= SPACING.
- Latency:
  - New x values appear 1 cycle after tick (if pending and idle).
  - Fastest spawn completes tick+4 cycles with same-cycle ack.
- All slots full: no request; dist saturates; spawn occurs at the first tick after a retire.
- rst mid-REQ: rnd_req=0 next cycle; all state returns to reset values.
- Outputs are registered; x and y change only in SCROLL/LOAD.

Decomposition:
- Shared package game_pkg holds:
  - X_W=9 and Y_W=9.
  - The scheduler state enum.
  - SCREEN_W, START_X default, and SPACING default constants.
- Sub-module tick_divider (TICK_DIV parameter, enable, tick pulse). The team reuses it for other timed objects.
- Slot array and FSM stay in obstacle_scheduler.

Test Plan (TICK_DIV=4 in simulation):
- Reset, enable=1, speed=2, ack 2 cycles after req with height 100 → first tick spawns slot0 with x=320, y=100, active=001.
- Steady scroll, speed=2: each tick slot0 x decreases by 2 (318, 316, ...). After 60 ticks dist reaches 120 → slot1 spawns at 320.
- Retire: force slot0 x=3, speed=4 → after next tick active bit0=0 and x stays 3. The next spawn reuses slot0.
- Full pool: SPACING=4, speed=8, three spawns → active=111. Next tick gives rnd_req=0 and dist saturates. After a forced retire, a spawn occurs on the following tick.
- Handshake stall: withhold rnd_ack for 50 cycles, toggle enable low → rnd_req stays high. Extra ticks set pending only once. After ack, LOAD completes, then one SCROLL runs.
- Synchronous reset asserted during REQ → rnd_req=0, active=000, dist=120 the next cycle. No stray load occurs when a late ack arrives.
